// File: rtl/count_display_pkg.sv
// Shared constants for the count_display block: FSM encoding, digit count and
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high).
package count_display_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/count_display_seg7_decode.sv
// Combinational BCD digit to seven-segment pattern; blank forces all segments off.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_display.sv
// Binary-to-BCD (double-dabble, one iteration per clock) feeding a 3-digit
// multiplexed seven-segment scanner with optional leading-zero blanking.
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  state_t      state_q, state_d;
  logic [7:0]  last_value_q, last_value_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic [11:0] bcd_q, bcd_d;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  sel_q, sel_d;

  logic [7:0]  shift_q, shift_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  iter_q, iter_d;

  logic [3:0]  digit_cur;
  logic        blank_cur;

  function automatic logic [11:0] add3_nibbles(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    last_value_d = last_value_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    bcd_valid_d  = 1'b0;
    bcd_d        = bcd_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    iter_d       = iter_q;

    case (state_q)
      ST_IDLE: begin
        if (pending_q || (value != last_value_q)) begin
          shift_d      = value;
          last_value_d = value;
          acc_d        = '0;
          iter_d       = '0;
          pending_d    = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {acc_d, shift_d} = {add3_nibbles(acc_q), shift_q} << 1;
        iter_d           = iter_q + 3'd1;
        // bcd_q also serves as the display digit latch, so the scan switches atomically
        if (iter_q == 3'd7) begin
          bcd_d       = acc_d;
          bcd_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + 16'd1;
    sel_d   = sel_q;
    if (presc_q == 16'(SCAN_DIV - 1)) begin
      presc_d = '0;
      sel_d   = (sel_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_value_q <= '0;
      pending_q    <= 1'b1;
      busy_q       <= 1'b0;
      bcd_valid_q  <= 1'b0;
      bcd_q        <= '0;
      presc_q      <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      bcd_valid_q  <= bcd_valid_d;
      bcd_q        <= bcd_d;
      presc_q      <= presc_d;
      sel_q        <= sel_d;
    end
  end

  // Datapath working registers are always loaded before use, so they need no reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    acc_q   <= acc_d;
    iter_q  <= iter_d;
  end

  always_comb begin
    digit_cur = bcd_q[3:0];
    blank_cur = 1'b0;
    case (sel_q)
      2'd1: begin
        digit_cur = bcd_q[7:4];
        blank_cur = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit_cur = bcd_q[11:8];
        blank_cur = BLANK_LZ && (bcd_q[11:8] == 4'd0);
      end
      default: begin
        digit_cur = bcd_q[3:0];
        blank_cur = 1'b0;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (digit_cur),
    .blank (blank_cur),
    .seg   (seg)
  );

  assign an        = 3'(3'b001 << sel_q);
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display: one instance with leading-zero blanking,
// one without, driven by the same clock, reset and value.
module tb_count_display;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101, S7 = 7'b0000111, S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1101111, SB = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  value = 8'd0;
  logic [11:0] bcd, bcd2;
  logic        bcd_valid, bcd_valid2, busy, busy2;
  logic [2:0]  an, an2;
  logic [6:0]  seg, seg2;

  int n_cmp = 0;
  int n_fail = 0;

  count_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .bcd(bcd), .bcd_valid(bcd_valid),
    .busy(busy), .an(an), .seg(seg)
  );

  count_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .value(value), .bcd(bcd2), .bcd_valid(bcd_valid2),
    .busy(busy2), .an(an2), .seg(seg2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] bcd;
    logic [20:0] segs_lz;  // {hundreds, tens, units} with blanking
    logic [20:0] segs_nb;  // {hundreds, tens, units} without blanking
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bcd_valid && cyc < 40);
  endtask

  task automatic read_slots(output logic [20:0] s_lz, output logic [20:0] s_nb);
    s_lz = '0;
    s_nb = '0;
    for (int s = 0; s < 3; s++) begin
      int n = 0;
      while (an != 3'(3'b001 << s) && n < 16) begin
        tick();
        n++;
      end
      chk($sformatf("an_reach_%0d", s), {31'd0, an == 3'(3'b001 << s)}, 32'd1);
      s_lz[7*s +: 7] = seg;
      s_nb[7*s +: 7] = seg2;
    end
  endtask

  initial begin
    int          cyc;
    logic [20:0] s_lz, s_nb;
    logic [2:0]  prev_an;

    vecs[0] = '{8'd255, 12'h255, {S2, S5, S5}, {S2, S5, S5}};
    vecs[1] = '{8'd100, 12'h100, {S1, S0, S0}, {S1, S0, S0}};
    vecs[2] = '{8'd7,   12'h007, {SB, SB, S7}, {S0, S0, S7}};
    vecs[3] = '{8'd45,  12'h045, {SB, S4, S5}, {S0, S4, S5}};
    vecs[4] = '{8'd9,   12'h009, {SB, SB, S9}, {S0, S0, S9}};
    vecs[5] = '{8'd138, 12'h138, {S1, S3, S8}, {S1, S3, S8}};
    vecs[6] = '{8'd60,  12'h060, {SB, S6, S0}, {S0, S6, S0}};
    vecs[7] = '{8'd201, 12'h201, {S2, S0, S1}, {S2, S0, S1}};

    // Reset state, then the pending-forced first conversion of 0
    reset = 1'b0;
    value = 8'd0;
    tick();
    tick();
    chk("rst_bcd", {20'd0, bcd}, 32'h000);
    chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_an", {29'd0, an}, 32'b001);
    reset = 1'b1;
    tick();
    chk("pend_busy", {31'd0, busy}, 32'd1);
    wait_valid(cyc);
    chk("pend_latency", cyc + 1, 32'd9);
    chk("pend_bcd", {20'd0, bcd}, 32'h000);
    read_slots(s_lz, s_nb);
    chk("pend_seg_u", {25'd0, s_lz[6:0]}, {25'd0, S0});
    chk("pend_seg_t", {25'd0, s_lz[13:7]}, {25'd0, SB});
    chk("pend_seg_h", {25'd0, s_lz[20:14]}, {25'd0, SB});

    // Table of single conversions from an idle start
    for (int i = 0; i < 8; i++) begin
      value = vecs[i].v;
      tick();
      chk($sformatf("v%0d_busy", vecs[i].v), {31'd0, busy}, 32'd1);
      wait_valid(cyc);
      chk($sformatf("v%0d_latency", vecs[i].v), cyc + 1, 32'd9);
      chk($sformatf("v%0d_bcd", vecs[i].v), {20'd0, bcd}, {20'd0, vecs[i].bcd});
      chk($sformatf("v%0d_busy_done", vecs[i].v), {31'd0, busy}, 32'd0);
      tick();
      chk($sformatf("v%0d_valid_pulse", vecs[i].v), {31'd0, bcd_valid}, 32'd0);
      read_slots(s_lz, s_nb);
      chk($sformatf("v%0d_segs_lz", vecs[i].v), {11'd0, s_lz}, {11'd0, vecs[i].segs_lz});
      chk($sformatf("v%0d_segs_nb", vecs[i].v), {11'd0, s_nb}, {11'd0, vecs[i].segs_nb});
    end

    // Change during conversion: 12 then 34 arriving at E3
    value = 8'd12;
    tick();
    tick();
    tick();
    value = 8'd34;
    wait_valid(cyc);
    chk("chg_first_latency", cyc + 3, 32'd9);
    chk("chg_first_bcd", {20'd0, bcd}, 32'h012);
    wait_valid(cyc);
    chk("chg_second_latency", cyc, 32'd9);
    chk("chg_second_bcd", {20'd0, bcd}, 32'h034);

    // Reset asserted at E4 of converting 200
    value = 8'd200;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("abort_bcd", {20'd0, bcd}, 32'h000);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, bcd_valid}, 32'd0);
    chk("abort_an", {29'd0, an}, 32'b001);
    tick();
    chk("abort_valid_hold", {31'd0, bcd_valid}, 32'd0);
    reset = 1'b1;
    wait_valid(cyc);
    chk("abort_latency", cyc, 32'd9);
    chk("abort_bcd_after", {20'd0, bcd}, 32'h200);

    // Scan cadence while a conversion runs alongside
    value = 8'd77;
    prev_an = an;
    cyc = 0;
    while (an == prev_an && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("scan_first_rotate", {29'd0, an}, {29'd0, prev_an[1:0], prev_an[2]});
    for (int k = 0; k < 4; k++) begin
      prev_an = an;
      cyc = 0;
      while (an == prev_an && cyc < 10) begin
        tick();
        cyc++;
      end
      chk($sformatf("scan_period_%0d", k), cyc, 32'd4);
      chk($sformatf("scan_rotate_%0d", k), {29'd0, an}, {29'd0, prev_an[1:0], prev_an[2]});
    end
    wait_valid(cyc);
    chk("scan_conv_bcd", {20'd0, bcd}, 32'h077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
